// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: issues one instruction-bus request at a time,
// buffers the returned word until downstream takes it, and absorbs redirects.
module pc_fetch_ctrl #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [63:0] inst_pc,
  output logic [63:0] fetch_count,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] pend_pc;

  // Bus handshake: a request is outstanding while ireq_valid=1; ireq_addr is
  // held constant until the cycle iresp_ok=1, which completes it. iresp_ok seen
  // while ireq_valid=0 belongs to no request and is ignored.
  assign ireq_addr = pc;
  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= PC_RESET;
      pend_pc     <= 64'd0;
      inst_out    <= 32'd0;
      inst_pc     <= 64'd0;
      fetch_count <= 64'd0;
      ireq_valid  <= 1'b0;
      inst_valid  <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (!ireq_valid) begin
            // First cycle out of reset: no request yet, so nothing to drop.
            ireq_valid <= 1'b1;
            if (redirect_valid) pc <= redirect_pc;
          end else if (iresp_ok && !redirect_valid) begin
            inst_out   <= iresp_data;
            inst_pc    <= pc;
            ireq_valid <= 1'b0;
            inst_valid <= 1'b1;
            state      <= HOLD;
          end else if (iresp_ok) begin
            pc <= redirect_pc;
          end else if (redirect_valid) begin
            // Request still in flight: wait for it to land, then retarget.
            pend_pc <= redirect_pc;
            state   <= DROP;
          end
        end
        DROP: begin
          if (redirect_valid) pend_pc <= redirect_pc;
          if (iresp_ok) begin
            pc    <= redirect_valid ? redirect_pc : pend_pc;
            state <= FETCH;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc         <= redirect_pc;
            ireq_valid <= 1'b1;
            inst_valid <= 1'b0;
            state      <= FETCH;
          end else if (!stall) begin
            pc          <= pc + 64'd4;
            fetch_count <= fetch_count + 64'd1;
            ireq_valid  <= 1'b1;
            inst_valid  <= 1'b0;
            state       <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural fetch model.
module tb_pc_fetch_ctrl;

  localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [63:0] inst_pc;
  logic [63:0] fetch_count;
  logic [1:0]  fsm_state;

  pc_fetch_ctrl #(.PC_RESET(PC_RESET)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_ok(iresp_ok), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
    .fetch_count(fetch_count), .fsm_state(fsm_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: current fetch address, optional buffered instruction,
  // optional pending redirect target while a doomed request drains
  typedef struct {
    logic [31:0] data;
    logic [63:0] pc;
  } held_t;

  held_t       m_held[$];
  logic [63:0] m_pc;
  logic [63:0] m_pend;
  logic [63:0] m_count;
  bit          m_started;
  bit          m_drop;

  function automatic bit exp_ireq();
    return m_started && (m_held.size() == 0);
  endfunction

  task automatic model_reset();
    m_held.delete();
    m_pc      = PC_RESET;
    m_pend    = 64'd0;
    m_count   = 64'd0;
    m_started = 1'b0;
    m_drop    = 1'b0;
  endtask

  task automatic model_step();
    if (m_held.size() != 0) begin
      if (redirect_valid) begin
        m_held.delete();
        m_pc = redirect_pc;
      end else if (!stall) begin
        m_held.delete();
        m_pc    = m_pc + 64'd4;
        m_count = m_count + 64'd1;
      end
    end else if (!m_started) begin
      m_started = 1'b1;
      if (redirect_valid) m_pc = redirect_pc;
    end else if (m_drop) begin
      if (redirect_valid) m_pend = redirect_pc;
      if (iresp_ok) begin
        m_pc   = m_pend;
        m_drop = 1'b0;
      end
    end else if (iresp_ok && !redirect_valid) begin
      m_held.push_back('{data: iresp_data, pc: m_pc});
    end else if (iresp_ok) begin
      m_pc = redirect_pc;
    end else if (redirect_valid) begin
      m_drop = 1'b1;
      m_pend = redirect_pc;
    end
  endtask

  task automatic compare_model();
    bit ev;
    ev = exp_ireq();
    chk("ireq_valid", {63'd0, ireq_valid}, {63'd0, ev});
    if (ev) chk("ireq_addr", ireq_addr, m_pc);
    chk("inst_valid", {63'd0, inst_valid}, {63'd0, m_held.size() != 0});
    if (m_held.size() != 0) begin
      chk("inst_out", {32'd0, inst_out}, {32'd0, m_held[0].data});
      chk("inst_pc", inst_pc, m_held[0].pc);
    end
    chk("fetch_count", fetch_count, m_count);
  endtask

  // driver tasks
  task automatic set_in(input bit ok, input logic [31:0] d, input bit rv,
                        input logic [63:0] rp, input bit st);
    iresp_ok       = ok;
    iresp_data     = d;
    redirect_valid = rv;
    redirect_pc    = rp;
    stall          = st;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle();
    set_in(0, 32'd0, 0, 64'd0, 0);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ireq_valid"}, {63'd0, ireq_valid}, 64'd0);
    chk({tag, "_inst_valid"}, {63'd0, inst_valid}, 64'd0);
    chk({tag, "_ireq_addr"}, ireq_addr, PC_RESET);
    chk({tag, "_inst_out"}, {32'd0, inst_out}, 64'd0);
    chk({tag, "_inst_pc"}, inst_pc, 64'd0);
    chk({tag, "_fetch_count"}, fetch_count, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(0, 32'd0, 0, 64'd0, 0);
    #1;
    check_reset_outputs("reset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset_no_req", {63'd0, ireq_valid}, 64'd0);
  endtask

  task automatic rand_cycle();
    bit          ok;
    bit          rv;
    logic [63:0] rp;
    if (exp_ireq()) ok = ($urandom_range(0, 2) == 0);
    else            ok = ($urandom_range(0, 3) == 0);
    rv = ($urandom_range(0, 7) == 0);
    case ($urandom_range(0, 3))
      0:       rp = 64'hFFFF_FFFF_FFFF_FFF8;
      1:       rp = {$urandom, $urandom};
      default: rp = PC_RESET + {52'd0, $urandom_range(0, 1023), 2'b00};
    endcase
    set_in(ok, $urandom, rv, rp, ($urandom_range(0, 2) == 0));
    tick();
  endtask

  initial begin
    set_in(0, 32'd0, 0, 64'd0, 0);
    @(negedge clk);
    do_reset();

    // straight-line fetches
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("line_addr", ireq_addr, PC_RESET + 64'(4 * i));
      idle();
      set_in(1, 32'hA000_0000 + 32'(i), 0, 64'd0, 0);
      tick();
      chk("line_inst_pc", inst_pc, PC_RESET + 64'(4 * i));
      idle();
    end
    chk("line_count", fetch_count, 64'd3);
    chk("line_next_addr", ireq_addr, 64'h8000_000C);

    // stall hold
    set_in(1, 32'h0000_0013, 0, 64'd0, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 32'd0, 0, 64'd0, 1);
      tick();
      chk("stall_valid", {63'd0, inst_valid}, 64'd1);
      chk("stall_inst", {32'd0, inst_out}, 64'h13);
      chk("stall_noreq", {63'd0, ireq_valid}, 64'd0);
      chk("stall_count", fetch_count, 64'd3);
    end
    idle();
    chk("stall_count_after", fetch_count, 64'd4);

    // redirect while waiting
    do_reset();
    idle();
    set_in(0, 32'd0, 1, 64'h8000_0100, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("drop_addr_held", ireq_addr, 64'h8000_0000);
      idle();
    end
    set_in(1, 32'hDEAD_BEEF, 0, 64'd0, 0);
    tick();
    chk("drop_discard", {63'd0, inst_valid}, 64'd0);
    chk("drop_next_addr", ireq_addr, 64'h8000_0100);
    chk("drop_count", fetch_count, 64'd0);

    // double redirect in DROP, then redirect coincident with ok
    set_in(0, 32'd0, 1, 64'h100, 0); tick();
    set_in(0, 32'd0, 1, 64'h200, 0); tick();
    set_in(1, 32'h1111_1111, 0, 64'd0, 0); tick();
    chk("dbl_redirect_addr", ireq_addr, 64'h200);
    set_in(0, 32'd0, 1, 64'h250, 0); tick();
    set_in(1, 32'h2222_2222, 1, 64'h300, 0); tick();
    chk("coincident_addr", ireq_addr, 64'h300);

    // redirect in HOLD beats stall
    set_in(1, 32'h3333_3333, 0, 64'd0, 1); tick();
    set_in(0, 32'd0, 0, 64'd0, 1); tick();
    set_in(0, 32'd0, 1, 64'h8000_0040, 1); tick();
    chk("hold_redir_valid", {63'd0, inst_valid}, 64'd0);
    chk("hold_redir_addr", ireq_addr, 64'h8000_0040);
    chk("hold_redir_count", fetch_count, 64'd0);

    // wrap of pc+4
    set_in(1, 32'd0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0); tick();
    set_in(1, 32'h4444_4444, 0, 64'd0, 0); tick();
    chk("wrap_inst_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    idle();
    chk("wrap_addr", ireq_addr, 64'd0);
    chk("wrap_count", fetch_count, 64'd1);

    // asynchronous reset while in DROP
    set_in(0, 32'd0, 1, 64'h500, 0); tick();
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    do_reset();

    // randomized run
    for (int i = 0; i < 3000; i++) rand_cycle();
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 3000; i++) rand_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
